// File: rtl/lab3_vector_sequencer_pkg.sv
// Shared definitions for the lab3 vector sequencer: sizes and FSM states.
package lab3_vector_sequencer_pkg;

  localparam int unsigned VEC_W   = 3;
  localparam int unsigned NUM_VEC = 8;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/lab3_settle_counter.sv
// Loadable down-counter that times how long each vector is held before sampling.
// It stops at zero; zero stays asserted until the next load.
module lab3_settle_counter
  import lab3_vector_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: a load wins, otherwise count down and stop at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lab3_vector_sequencer.sv
// Sweeps all eight {X,Y,Z} vectors into the block under test, samples F after a
// settle interval, and compares the captured truth table against EXP_TABLE.
module lab3_vector_sequencer
  import lab3_vector_sequencer_pkg::*;
#(
  parameter int unsigned          SETTLE_CYCLES = 2,
  parameter logic [NUM_VEC-1:0]   EXP_TABLE     = 8'b0110_1001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               f_in,
  output logic               x_out,
  output logic               y_out,
  output logic               z_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] captured,
  output logic [NUM_VEC-1:0] mismatch,
  output logic [3:0]         err_count
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(NUM_VEC - 1);

  state_e               state_q, state_d;
  logic [VEC_W-1:0]     idx_q, idx_d;
  logic [VEC_W-1:0]     xyz_q, xyz_d;
  logic [NUM_VEC-1:0]   captured_q, captured_d;
  logic [NUM_VEC-1:0]   mismatch_q, mismatch_d;
  logic [3:0]           err_count_q, err_count_d;
  logic                 pass_q, pass_d;
  logic                 cnt_load;
  logic                 cnt_zero;
  logic                 miss;

  lab3_settle_counter u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .zero     (cnt_zero)
  );

  // Next-state, drive and capture/compare logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    xyz_d       = xyz_q;
    captured_d  = captured_q;
    mismatch_d  = mismatch_q;
    err_count_d = err_count_q;
    pass_d      = pass_q;
    cnt_load    = 1'b0;
    miss        = f_in ^ EXP_TABLE[idx_q];

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d       = '0;
          xyz_d       = '0;
          captured_d  = '0;
          mismatch_d  = '0;
          err_count_d = '0;
          pass_d      = 1'b0;
          cnt_load    = 1'b1;
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        captured_d[idx_q] = f_in;
        mismatch_d[idx_q] = miss;
        err_count_d       = err_count_q + {3'b000, miss};
        if (idx_q == LAST_IDX) begin
          // pass is settled on entry to DONE so it is already valid with the done pulse
          pass_d  = (err_count_d == '0) && (mismatch_d == '0);
          state_d = ST_DONE;
        end else begin
          idx_d    = idx_q + 1'b1;
          xyz_d    = idx_q + 1'b1;
          cnt_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      xyz_q       <= '0;
      captured_q  <= '0;
      mismatch_q  <= '0;
      err_count_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      xyz_q       <= xyz_d;
      captured_q  <= captured_d;
      mismatch_q  <= mismatch_d;
      err_count_q <= err_count_d;
      pass_q      <= pass_d;
    end
  end

  assign x_out     = xyz_q[2];
  assign y_out     = xyz_q[1];
  assign z_out     = xyz_q[0];
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign captured  = captured_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_count_q;

endmodule
